rdl_subreg_counter: RTL
=======================

Name: rdl_subreg_counter

Overview:
- SystemRDL counter-field stage; computes next-state and enable for one counter field and holds its value.
- Sits between the register bus decode (software write/read strobes) and hardware event sources, in place of a plain storage flop.
- Provides:
  - increment and decrement by variable amounts
  - wrap or saturate on overflow and underflow
  - optional read-to-clear
  - registered overflow and underflow event pulses

Parameters:
- DW, 32, counter and software data width (1..64).
- IncrW, 1, width of incr_val and decr_val (1..DW).
- ResetValue, '0, DW-bit value loaded on reset and on hw_clr.
- Saturate, 1'b0: 0 = wrap modulo 2^DW; 1 = clamp at 2^DW-1 and at 0.
- ReadClear, 1'b0: 1 = a software read clears the counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- sw_we  input  1  software write strobe, single cycle.
- sw_wd  input  DW  software write data.
- sw_re  input  1  software read strobe, single cycle.
- incr  input  1  increment request.
- incr_val  input  IncrW  increment amount; 0 is legal (no-op).
- decr  input  1  decrement request.
- decr_val  input  IncrW  decrement amount.
- hw_clr  input  1  hardware clear.
- q  output  DW  current counter value; software read data.
- overflow  output  1  one-cycle pulse: last update exceeded 2^DW-1.
- underflow  output  1  one-cycle pulse: last update went below 0.

Behaviour:
- Reset (async assert, release on clk edge): q = ResetValue, overflow = 0, underflow = 0.
- All state updates on posedge clk; q reflects an update one cycle after the strobe. overflow and underflow assert in that same cycle and last exactly one cycle.
- Update priority, highest first:
  1. hw_clr: q <= ResetValue. incr, decr, sw_re, sw_we ignored; no event pulses.
  2. sw_we: q <= sw_wd. incr and decr in the same cycle are dropped; no pulses.
  3. sw_re with ReadClear=1: base = 0. Otherwise base = q.
  4. incr/decr arithmetic applied to base.
- Read data: the bus samples q combinationally during the sw_re cycle, i.e. the pre-clear value.
- Arithmetic:
  - sum = base + (incr ? incr_val : 0) - (decr ? decr_val : 0), computed signed in DW+2 bits.
  - sum > 2^DW-1: overflow pulse; q <= Saturate ? all-ones : sum[DW-1:0].
  - sum < 0: underflow pulse; q <= Saturate ? 0 : sum[DW-1:0].
  - Otherwise q <= sum[DW-1:0].
- incr and decr together: net effect only. E.g. incr_val = decr_val gives no change and no pulse, even when q is at a boundary.
- Read-clear together with incr: counter restarts from the increment, so no event is lost. Read-clear together with decr only: underflow rules apply against base 0.
- Saturated counter receiving further incr: q stays all-ones; overflow pulses on every such cycle.
- No state machine beyond the q/flag registers. q changes only when an update enable is true, so idle cycles hold q.

Optional Feature:
- Macro RDL_SUBREG_COUNTER_THRESHOLD_EN.
- Defined:
  - Adds input threshold [DW] and output thr_hit [1].
  - thr_hit is a registered level, high while q >= threshold. It updates in the same cycle as q and resets to 0.
  - Also adds output thr_event [1]: one-cycle pulse on the 0->1 transition of thr_hit.
- Undefined: these ports do not exist and no comparator logic is built.

Test Plan:
- Reset and idle: assert rst mid-count with q=0x10 and ResetValue=0x5 -> q=0x5 immediately (async), no pulses, q holds 0x5 for 10 idle cycles.
- Wrap overflow: DW=8, Saturate=0, q=0xFE, incr with incr_val=3 -> next cycle q=0x01 and overflow=1 for exactly one cycle. Decrement by 2 from q=0x01 -> q=0xFF, underflow pulse.
- Saturation: Saturate=1, q=0xFE, incr_val=3 held for 3 cycles -> q=0xFF, overflow high each cycle. Then decr_val=0xFF twice -> q=0x00, then 0x00 with underflow on the second.
- Priority: in one cycle assert hw_clr, sw_we with sw_wd=0xAA, and incr -> q=ResetValue. Next, sw_we with 0xAA plus incr -> q=0xAA, no pulse.
- Read-clear: ReadClear=1, q=0x40, sw_re plus incr with incr_val=1 -> bus samples 0x40, next q=0x01. With ReadClear=0 the same stimulus gives q=0x41.
- Threshold (macro defined): threshold=0x10, q stepping 0x0E, 0x0F, 0x10, 0x11 -> thr_hit rises with q=0x10, thr_event pulses once. sw_we of 0x00 drops thr_hit the next cycle.

Source files
------------

// File: rtl/rdl_subreg_counter.sv
// SystemRDL counter-field stage: next-state, enable and storage for one counter field.
// Define RDL_SUBREG_COUNTER_THRESHOLD_EN to add the threshold comparator (threshold, thr_hit, thr_event).
module rdl_subreg_counter #(
  parameter int unsigned   DW         = 32,
  parameter int unsigned   IncrW      = 1,
  parameter logic [DW-1:0] ResetValue = '0,
  parameter bit            Saturate   = 1'b0,
  parameter bit            ReadClear  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_we,
  input  logic [DW-1:0]    sw_wd,
  input  logic             sw_re,
  input  logic             incr,
  input  logic [IncrW-1:0] incr_val,
  input  logic             decr,
  input  logic [IncrW-1:0] decr_val,
  input  logic             hw_clr,
`ifdef RDL_SUBREG_COUNTER_THRESHOLD_EN
  input  logic [DW-1:0]    threshold,
  output logic             thr_hit,
  output logic             thr_event,
`endif
  output logic [DW-1:0]    q,
  output logic             overflow,
  output logic             underflow
);

  // Two guard bits: one for the carry past 2^DW-1, one as the sign of a borrow below 0.
  localparam int unsigned SW = DW + 2;

  logic [DW-1:0] q_d, q_q;
  logic          overflow_d, overflow_q;
  logic          underflow_d, underflow_q;

  logic [DW-1:0] base;
  logic [SW-1:0] add_amt;
  logic [SW-1:0] sub_amt;
  logic [SW-1:0] sum;
  logic          sum_over;
  logic          sum_under;
  logic          arith_en;

  always_comb begin
    base      = (sw_re && ReadClear) ? '0 : q_q;
    add_amt   = incr ? SW'(incr_val) : '0;
    sub_amt   = decr ? SW'(decr_val) : '0;
    sum       = SW'(base) + add_amt - sub_amt;
    sum_under = sum[SW-1];
    sum_over  = ~sum[SW-1] & sum[SW-2];
    arith_en  = incr | decr | (sw_re && ReadClear);
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    q_d         = q_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (hw_clr) begin
      q_d = ResetValue;
    end else if (sw_we) begin
      q_d = sw_wd;
    end else if (arith_en) begin
      if (sum_over) begin
        overflow_d = 1'b1;
        q_d        = Saturate ? '1 : sum[DW-1:0];
      end else if (sum_under) begin
        underflow_d = 1'b1;
        q_d         = Saturate ? '0 : sum[DW-1:0];
      end else begin
        q_d = sum[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      q_q         <= ResetValue;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign q         = q_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef RDL_SUBREG_COUNTER_THRESHOLD_EN
  logic thr_hit_d, thr_hit_q;
  logic thr_event_d, thr_event_q;

  // Compare against the next value so thr_hit moves in the same cycle as q.
  always_comb begin
    thr_hit_d   = (q_d >= threshold);
    thr_event_d = thr_hit_d & ~thr_hit_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_hit_q   <= 1'b0;
      thr_event_q <= 1'b0;
    end else begin
      thr_hit_q   <= thr_hit_d;
      thr_event_q <= thr_event_d;
    end
  end

  assign thr_hit   = thr_hit_q;
  assign thr_event = thr_event_q;
`endif

endmodule
